// File: rtl/sumnb_serial.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell per clock, LSB first,
// with a start/busy/done handshake and results held until the next accepted start.
module sumnb_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Subtraction is a + ~b + 1, so B is inverted at load and the carry preset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= sub ? ~b : b;
            r_c    <= sub ? 1'b1 : cin;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        S_RUN: begin
          r_sum <= {w_s, r_sum[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_c;
            r_ovf  <= r_c ^ w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_sumnb_serial.sv
// Directed, exhaustive (WIDTH=4) and random (WIDTH=8/32) checks of sumnb_serial
// against an arithmetic reference model.
module tb_sumnb_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st4 = 1'b0, st8 = 1'b0, st32 = 1'b0;
  logic [31:0] a_bus = '0, b_bus = '0;
  logic        cin_r = 1'b0, sub_r = 1'b0;

  logic [3:0]  sum4;  logic cout4,  ovf4,  busy4,  done4;
  logic [7:0]  sum8;  logic cout8,  ovf8,  busy8,  done8;
  logic [31:0] sum32; logic cout32, ovf32, busy32, done32;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sumnb_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .a(a_bus[3:0]), .b(b_bus[3:0]),
    .cin(cin_r), .sub(sub_r), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .busy(busy4), .done(done4));

  sumnb_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a_bus[7:0]), .b(b_bus[7:0]),
    .cin(cin_r), .sub(sub_r), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .busy(busy8), .done(done8));

  sumnb_serial #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st32), .a(a_bus), .b(b_bus),
    .cin(cin_r), .sub(sub_r), .sum(sum32), .cout(cout32), .ovf(ovf32),
    .busy(busy32), .done(done32));

  typedef struct {
    logic [3:0] a, b;
    logic       cin, sub;
    logic [3:0] sum;
    logic       cout, ovf;
  } vec_t;

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns {ovf, cout, sum[31:0]} computed with plain integer arithmetic.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                         input logic ci, input logic sb);
    longint unsigned mask, m1, aa, bb, c0, full, low, co, cm;
    mask = (64'd1 << w) - 1;
    m1   = mask >> 1;
    aa   = longint'(ai) & mask;
    bb   = sb ? (~longint'(bi)) & mask : longint'(bi) & mask;
    c0   = sb ? 1 : longint'(ci);
    full = aa + bb + c0;
    low  = (aa & m1) + (bb & m1) + c0;
    co   = (full >> w) & 1;
    cm   = (low >> (w - 1)) & 1;
    return {1'(cm ^ co), 1'(co), 32'(full & mask)};
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      4:       return done4;
      8:       return done8;
      default: return done32;
    endcase
  endfunction

  task automatic do_op(input int w, input logic [31:0] ai, input logic [31:0] bi,
                       input logic ci, input logic sb,
                       output logic [33:0] res, output int lat);
    @(negedge clk);
    a_bus = ai; b_bus = bi; cin_r = ci; sub_r = sb;
    case (w) 4: st4 = 1'b1; 8: st8 = 1'b1; default: st32 = 1'b1; endcase
    @(negedge clk);
    st4 = 1'b0; st8 = 1'b0; st32 = 1'b0;
    lat = 0;
    while (!get_done(w) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    case (w)
      4:       res = {ovf4, cout4, 28'd0, sum4};
      8:       res = {ovf8, cout8, 24'd0, sum8};
      default: res = {ovf32, cout32, sum32};
    endcase
  endtask

  initial begin
    vec_t        vt[7];
    logic [33:0] res, exp;
    int          lat, n, last_done, pulses;
    logic        ok, prev_done;
    logic [31:0] ra, rb;

    vt[0] = '{a:4'd7,  b:4'd9, cin:1'b0, sub:1'b0, sum:4'd0,  cout:1'b1, ovf:1'b0};
    vt[1] = '{a:4'd7,  b:4'd1, cin:1'b0, sub:1'b0, sum:4'd8,  cout:1'b0, ovf:1'b1};
    vt[2] = '{a:4'd15, b:4'd0, cin:1'b1, sub:1'b0, sum:4'd0,  cout:1'b1, ovf:1'b0};
    vt[3] = '{a:4'd3,  b:4'd5, cin:1'b0, sub:1'b1, sum:4'd14, cout:1'b0, ovf:1'b0};
    vt[4] = '{a:4'd8,  b:4'd1, cin:1'b1, sub:1'b1, sum:4'd7,  cout:1'b1, ovf:1'b1};
    vt[5] = '{a:4'd5,  b:4'd6, cin:1'b1, sub:1'b0, sum:4'd12, cout:1'b0, ovf:1'b1};
    vt[6] = '{a:4'd0,  b:4'd0, cin:1'b0, sub:1'b1, sum:4'd0,  cout:1'b1, ovf:1'b0};

    // Reset held two cycles with start asserted
    rst = 1'b1; st4 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sum", sum4, 0);
    check("rst_cout", cout4, 0);
    check("rst_ovf", ovf4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    rst = 1'b0; st4 = 1'b0;
    @(negedge clk);
    check("rst_nostart_busy", busy4, 0);

    foreach (vt[i]) begin
      do_op(4, {28'd0, vt[i].a}, {28'd0, vt[i].b}, vt[i].cin, vt[i].sub, res, lat);
      check($sformatf("vec%0d_lat", i), lat, 4);
      check($sformatf("vec%0d_sum", i), res[3:0], vt[i].sum);
      check($sformatf("vec%0d_cout", i), res[32], vt[i].cout);
      check($sformatf("vec%0d_ovf", i), res[33], vt[i].ovf);
    end

    // start re-pulsed and operands changed during RUN and DONE are ignored
    @(negedge clk);
    a_bus = 32'd7; b_bus = 32'd9; cin_r = 1'b0; sub_r = 1'b0; st4 = 1'b1;
    @(negedge clk);
    a_bus = 32'd1; b_bus = 32'd1; sub_r = 1'b1; cin_r = 1'b1;
    n = 0;
    while (!done4 && n < 100) begin @(negedge clk); n++; end
    check("hs_lat", n, 4);
    check("hs_sum", sum4, 0);
    check("hs_cout", cout4, 1);
    check("hs_ovf", ovf4, 0);
    @(negedge clk);
    check("hs_done_width", done4, 0);
    check("hs_idle_busy", busy4, 0);
    st4 = 1'b0;
    @(negedge clk);
    check("hs_no_restart", busy4, 0);
    check("hs_hold_sum", sum4, 0);
    check("hs_hold_cout", cout4, 1);

    // start held high: one operation every WIDTH+2 cycles
    a_bus = 32'd3; b_bus = 32'd4; cin_r = 1'b0; sub_r = 1'b0; st4 = 1'b1;
    last_done = -1; pulses = 0; prev_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done4) begin
        check("cont_double_done", prev_done, 0);
        check("cont_sum", sum4, 7);
        if (last_done >= 0) check("cont_period", c - last_done, 6);
        last_done = c;
        pulses++;
      end
      prev_done = done4;
    end
    check("cont_pulses_ge6", pulses >= 6, 1);
    st4 = 1'b0;
    n = 0;
    while ((busy4 || done4) && n < 20) begin @(negedge clk); n++; end
    check("cont_drain", busy4 | done4, 0);

    // Reset on the second RUN edge aborts the operation
    a_bus = 32'd7; b_bus = 32'd1; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sum", sum4, 0);
    check("abort_cout", cout4, 0);
    check("abort_ovf", ovf4, 0);
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    ok = 1'b1;
    repeat (8) begin @(negedge clk); if (done4 || busy4) ok = 1'b0; end
    check("abort_no_done", ok, 1);
    do_op(4, 32'd7, 32'd1, 1'b0, 1'b0, res, lat);
    check("after_abort_lat", lat, 4);
    check("after_abort_res", res, {1'b1, 1'b0, 32'd8});

    // Exhaustive WIDTH=4
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++) begin
            do_op(4, 32'(x), 32'(y), 1'(ci), 1'(s), res, lat);
            exp = ref_op(4, 32'(x), 32'(y), 1'(ci), 1'(s));
            if (lat != 4) check($sformatf("ex4_lat a=%0d b=%0d", x, y), lat, 4);
            check($sformatf("ex4 a=%0d b=%0d cin=%0d sub=%0d", x, y, ci, s), res, exp);
          end

    // Random WIDTH=8 and WIDTH=32
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'hFF; rb = $urandom & 32'hFF;
      ok = 1'($urandom); prev_done = 1'($urandom);
      do_op(8, ra, rb, ok, prev_done, res, lat);
      exp = ref_op(8, ra, rb, ok, prev_done);
      if (lat != 8) check("r8_lat", lat, 8);
      check($sformatf("r8 a=%0h b=%0h cin=%0d sub=%0d", ra, rb, ok, prev_done), res, exp);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      ok = 1'($urandom); prev_done = 1'($urandom);
      do_op(32, ra, rb, ok, prev_done, res, lat);
      exp = ref_op(32, ra, rb, ok, prev_done);
      if (lat != 32) check("r32_lat", lat, 32);
      check($sformatf("r32 a=%0h b=%0h cin=%0d sub=%0d", ra, rb, ok, prev_done), res, exp);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
